// File: rtl/elementwise_divider_seq_if.sv
// Handshake and data bundle for the sequential element-wise divider.
// The master drives the request side and takes results; the slave is the divider.
interface elementwise_divider_seq_if #(
  parameter int N = 8,
  parameter int M = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [M*2*N-1:0] dividend;
  logic [M*N-1:0]   divisor;
  logic             out_valid;
  logic             out_ready;
  logic [M*N-1:0]   quotient;
  logic [M*N-1:0]   remainder;
  logic [M-1:0]     div_zero;
  logic [M-1:0]     overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, overflow
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/elementwise_divider_seq.sv
// Sequential vector divider: one shared restoring divider walks the M element
// pairs in turn, one quotient bit per cycle, flagging zero-divide and overflow.
module elementwise_divider_seq #(
  parameter int N = 8,
  parameter int M = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  elementwise_divider_seq_if.slave    bus
);
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, DONE} state_e;

  state_e                 state_q, state_d;
  logic [M-1:0][2*N-1:0]  dvd_q, dvd_d;
  logic [M-1:0][N-1:0]    dvs_q, dvs_d;
  logic [M-1:0][N-1:0]    quo_q, quo_d;
  logic [M-1:0][N-1:0]    rem_q, rem_d;
  logic [M-1:0]           dz_q, dz_d;
  logic [M-1:0]           ov_q, ov_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  // acc holds {partial remainder, unconsumed dividend bits / quotient bits}
  logic [2*N-1:0]         acc_q, acc_d;

  logic [2*N-1:0]         dvd_cur;
  logic [N-1:0]           dvs_cur;
  logic [N:0]             trial, diff;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
  assign bus.overflow  = ov_q;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvd_cur = dvd_q[idx_q];
    dvs_cur = dvs_q[idx_q];
    trial   = {acc_q[2*N-1:N], acc_q[N-1]};
    // Partial remainder stays below the divisor, so diff[N] is a clean borrow.
    diff    = trial - {1'b0, dvs_cur};
    case (state_q)
      IDLE: if (bus.in_valid) begin
        dvd_d   = bus.dividend;
        dvs_d   = bus.divisor;
        dz_d    = '0;
        ov_d    = '0;
        idx_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        acc_d = dvd_cur;
        cnt_d = '0;
        if (dvs_cur == '0) begin
          dz_d[idx_q] = 1'b1;
          state_d     = STORE;
        end else if (dvd_cur[2*N-1:N] >= dvs_cur) begin
          ov_d[idx_q] = 1'b1;
          state_d     = STORE;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        if (!diff[N]) acc_d = {diff[N-1:0], acc_q[N-2:0], 1'b1};
        else          acc_d = {trial[N-1:0], acc_q[N-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = STORE;
      end
      STORE: begin
        if (dz_q[idx_q]) begin
          quo_d[idx_q] = '1;
          rem_d[idx_q] = acc_q[N-1:0];
        end else if (ov_q[idx_q]) begin
          quo_d[idx_q] = '1;
          rem_d[idx_q] = '0;
        end else begin
          quo_d[idx_q] = acc_q[N-1:0];
          rem_d[idx_q] = acc_q[2*N-1:N];
        end
        if (idx_q == IW'(M - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = LOAD;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= '0;
      ov_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_elementwise_divider_seq.sv
// Scoreboard bench: drivers push expected vectors on accept, per-DUT monitors
// pop and compare when out_valid appears, and keep comparing while it is held.
module tb_elementwise_divider_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [3:0]  dz;
    logic [3:0]  ov;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];

  elementwise_divider_seq_if #(.N(8), .M(4)) b4 ();
  elementwise_divider_seq_if #(.N(8), .M(2)) b2 ();

  elementwise_divider_seq #(.N(8), .M(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
  elementwise_divider_seq #(.N(8), .M(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  initial begin : mon4
    exp_t e;
    bit seen = 0;
    bit have = 0;
    forever begin
      @(negedge clk);
      if (b4.out_valid !== 1'b1) seen = 0;
      else begin
        if (!seen) begin
          seen = 1;
          have = (q4.size() != 0);
          if (!have) chk("dut4 unexpected out_valid", 80'd1, 80'd0);
          else begin
            e = q4.pop_front();
            chk("dut4 latency", 80'(cyc - e.acc), 80'(e.lat));
          end
        end
        if (have) begin
          chk("dut4 quotient/remainder", {b4.quotient, b4.remainder}, {e.q, e.r});
          chk("dut4 flags/in_ready", {b4.div_zero, b4.overflow, b4.in_ready}, {e.dz, e.ov, 1'b0});
        end
      end
    end
  end

  initial begin : mon2
    exp_t e;
    bit seen = 0;
    bit have = 0;
    forever begin
      @(negedge clk);
      if (b2.out_valid !== 1'b1) seen = 0;
      else begin
        if (!seen) begin
          seen = 1;
          have = (q2.size() != 0);
          if (!have) chk("dut2 unexpected out_valid", 80'd1, 80'd0);
          else begin
            e = q2.pop_front();
            chk("dut2 latency", 80'(cyc - e.acc), 80'(e.lat));
          end
        end
        if (have) begin
          chk("dut2 quotient/remainder", {b2.quotient, b2.remainder}, {e.q[15:0], e.r[15:0]});
          chk("dut2 flags/in_ready", {b2.div_zero, b2.overflow, b2.in_ready}, {e.dz[1:0], e.ov[1:0], 1'b0});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue4(input logic [63:0] dv, input logic [31:0] ds, output int acc);
    int n = 0;
    @(negedge clk);
    b4.dividend = dv; b4.divisor = ds; b4.in_valid = 1'b1;
    while (b4.in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (b4.in_ready !== 1'b1) chk("dut4 in_ready timeout", 80'd0, 80'd1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    // scramble inputs: the registered copy must be what gets divided
    b4.in_valid = 1'b0; b4.dividend = '1; b4.divisor = '0;
  endtask

  task automatic issue2(input logic [31:0] dv, input logic [15:0] ds, output int acc);
    int n = 0;
    @(negedge clk);
    b2.dividend = dv; b2.divisor = ds; b2.in_valid = 1'b1;
    while (b2.in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (b2.in_ready !== 1'b1) chk("dut2 in_ready timeout", 80'd0, 80'd1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    b2.in_valid = 1'b0; b2.dividend = '1; b2.divisor = '0;
  endtask

  task automatic wait_out4();
    int n = 0;
    while (b4.out_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (b4.out_valid !== 1'b1) chk("dut4 out_valid timeout", 80'd0, 80'd1);
  endtask

  task automatic wait_out2();
    int n = 0;
    while (b2.out_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (b2.out_valid !== 1'b1) chk("dut2 out_valid timeout", 80'd0, 80'd1);
  endtask

  task automatic run4(input logic [63:0] dv, input logic [31:0] ds, input logic [31:0] q,
                      input logic [31:0] r, input logic [3:0] dz, input logic [3:0] ov, input int lat);
    exp_t e;
    int   acc;
    issue4(dv, ds, acc);
    e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.lat = lat; e.acc = acc;
    q4.push_back(e);
    wait_out4();
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t e;
    int   acc;
    b4.in_valid = 1'b0; b4.out_ready = 1'b1; b4.dividend = '0; b4.divisor = '0;
    b2.in_valid = 1'b0; b2.out_ready = 1'b1; b2.dividend = '0; b2.divisor = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset dut4 handshake", {b4.in_ready, b4.out_valid}, 2'b10);
    chk("reset dut4 data", {b4.quotient, b4.remainder, b4.div_zero, b4.overflow}, '0);
    chk("reset dut2 handshake", {b2.in_ready, b2.out_valid}, 2'b10);
    chk("reset dut2 data", {b2.quotient, b2.remainder, b2.div_zero, b2.overflow}, '0);
    rst = 1'b0;

    // normal: 100/7, 1000/33, 255/255, 65024/255
    run4({16'd65024, 16'd255, 16'd1000, 16'd100}, {8'd255, 8'd255, 8'd33, 8'd7},
         {8'd254, 8'd1, 8'd30, 8'd14}, {8'd254, 8'd0, 8'd10, 8'd2}, 4'b0000, 4'b0000, 40);

    // flags: 50/0 zero-divide, 300/1 overflow
    run4({16'd0, 16'd9, 16'd300, 16'd50}, {8'd5, 8'd3, 8'd1, 8'd0},
         {8'd0, 8'd3, 8'd255, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd50}, 4'b0001, 4'b0010, 24);

    // boundaries: largest fitting quotient, tiny dividend, 256/1 just overflows
    run4({16'd256, 16'd255, 16'd1, 16'd65279}, {8'd1, 8'd1, 8'd2, 8'd255},
         {8'd255, 8'd255, 8'd0, 8'd255}, {8'd0, 8'd0, 8'd1, 8'd254}, 4'b0000, 4'b1000, 32);

    // backpressure: results held while out_ready low, new offers ignored
    b4.out_ready = 1'b0;
    issue4({16'd0, 16'd9, 16'd300, 16'd50}, {8'd5, 8'd3, 8'd1, 8'd0}, acc);
    e.q = {8'd0, 8'd3, 8'd255, 8'd255}; e.r = {8'd0, 8'd0, 8'd0, 8'd50};
    e.dz = 4'b0001; e.ov = 4'b0010; e.lat = 24; e.acc = acc;
    q4.push_back(e);
    wait_out4();
    b4.in_valid = 1'b1; b4.dividend = {4{16'd77}}; b4.divisor = {4{8'd3}};
    repeat (5) @(negedge clk);
    chk("backpressure still valid", {b4.out_valid, b4.in_ready}, 2'b10);
    b4.out_ready = 1'b1; b4.in_valid = 1'b0;
    @(negedge clk);
    chk("backpressure release", {b4.out_valid, b4.in_ready}, 2'b01);

    // reset mid-operation: no result for the aborted vector
    issue4({16'd65024, 16'd255, 16'd1000, 16'd100}, {8'd255, 8'd255, 8'd33, 8'd7}, acc);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-op reset handshake", {b4.in_ready, b4.out_valid}, 2'b10);
    chk("mid-op reset data", {b4.quotient, b4.remainder, b4.div_zero, b4.overflow}, '0);
    rst = 1'b0;
    run4({16'd65024, 16'd255, 16'd1000, 16'd100}, {8'd255, 8'd255, 8'd33, 8'd7},
         {8'd254, 8'd1, 8'd30, 8'd14}, {8'd254, 8'd0, 8'd10, 8'd2}, 4'b0000, 4'b0000, 40);

    // inverse of multiplier on the M=2 instance
    for (int j = 0; j < 8; j++) begin
      logic [7:0] a0, b0, a1, b1;
      a0 = 8'(j + 1);  b0 = 8'(8 - j);
      a1 = 8'(j + 11); b1 = 8'(18 - j);
      issue2({16'(a1 * b1), 16'(a0 * b0)}, {b1, b0}, acc);
      e.q = {16'd0, a1, a0}; e.r = '0; e.dz = '0; e.ov = '0; e.lat = 20; e.acc = acc;
      q2.push_back(e);
      wait_out2();
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboards drained", 80'(q4.size() + q2.size()), 80'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/elementwise_divider_seq.md
ELEMENTWISE_DIVIDER_SEQ -- requirements
Module: elementwise_divider_seq

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning element width in bits (divisor, quotient, remainder are N bits; dividend is 2N bits).
REQ-002 The block SHALL have parameter M, default 2, meaning number of element pairs per vector.
REQ-003 The block SHALL have port clk  input  1  the only clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  vector pair offered.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a vector pair.
REQ-007 The block SHALL have port dividend  input  M*2N  packed, element i at bits [i*2N +: 2N].
REQ-008 The block SHALL have port divisor  input  M*N  packed, element i at bits [i*N +: N].
REQ-009 The block SHALL have port out_valid  output  1  result vector available.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 The block SHALL have port quotient  output  M*N  packed, element i at [i*N +: N].
REQ-012 The block SHALL have port remainder  output  M*N  packed, element i at [i*N +: N].
REQ-013 The block SHALL have port div_zero  output  M  bit i set when divisor i is zero.
REQ-014 The block SHALL have port overflow  output  M  bit i set when quotient i does not fit in N bits.

Function
REQ-015 The block SHALL implement FSM states IDLE, LOAD, DIV, STORE, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-016 The block SHALL accept a transaction on a rising edge in IDLE with in_valid=1, register all dividend/divisor elements, clear div_zero/overflow, set index=0, go to LOAD; later input changes have no effect.
REQ-017 The block SHALL, in LOAD (1 cycle), load element[index]; divisor==0 -> set div_zero[index], go STORE; else dividend[2N-1:N] >= divisor -> set overflow[index], go STORE; else go DIV.
REQ-018 The block SHALL, in DIV, perform restoring division producing exactly one quotient bit per cycle, MSB first, for exactly N cycles, then go STORE.
REQ-019 The block SHALL, in STORE (1 cycle), write quotient/remainder slot index: normal -> true quotient and remainder; div_zero -> quotient all ones, remainder dividend[N-1:0]; overflow -> quotient all ones, remainder 0.
REQ-020 The block SHALL, from STORE, go to DONE when index==M-1, else increment index and go LOAD.
REQ-021 The block SHALL cost N+2 cycles per normal element and 2 cycles per flagged element; out_valid rises exactly the sum of these edges after the accepting edge (M*(N+2) if no flags).
REQ-022 The block SHALL hold quotient, remainder, div_zero, overflow stable while out_valid=1 and return to IDLE on the edge where out_valid&&out_ready; in_valid in DONE is ignored.
REQ-023 The block SHALL satisfy quotient*divisor+remainder==dividend and remainder<divisor for every unflagged element.

Reset
REQ-024 The block SHALL, on any edge with rst=1 in any state, go to IDLE, zero quotient, remainder, div_zero, overflow, index and datapath registers; out_valid=0, in_ready=1 after that edge.
REQ-025 The block SHALL discard a transaction in progress when reset and produce no out_valid for it.

Verification
REQ-026 Reset: rst=1 for 2 cycles -> in_ready=1, out_valid=0, all outputs 0.
REQ-027 Normal (N=8,M=4): dividends {100,1000,255,65024}, divisors {7,33,1... replaced by 255,255} i.e. divisors {7,33,255,255} -> quotient {14,30,1,254}, remainder {2,10,0,254}, flags 0, out_valid exactly 40 edges after accept.
REQ-028 Flags (N=8,M=4): dividends {50,300,9,0}, divisors {0,1,3,5} -> quotient {255,255,3,0}, remainder {50,0,0,0}, div_zero=4'b0001, overflow=4'b0010, out_valid 24 edges after accept.
REQ-029 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-030 Reset mid-op: rst=1 for 1 cycle 15 edges after accept -> no out_valid; next transaction of REQ-027 completes with identical results and latency.
REQ-031 Inverse of multiplier (N=8,M=2): dividend[i][j]=a*b with a=j+1+10i, b=(8-j)+10i over 8 runs -> quotient=a, remainder=0, flags 0.
